// File: rtl/bist_controller_if.sv
// -----------------------------------------------------------------------------
// bist_controller_if
// Request/grant handshake between the logic-BIST controller and the functional
// arbiter that owns the shared test resource.
//
// Signals
//   req_o   : controller -> arbiter, resource requested (REQ through COMPARE)
//   grant_i : arbiter -> controller, resource granted to the BIST session
//
// Modports
//   master : BIST controller side (drives req_o, samples grant_i)
//   slave  : arbiter side (samples req_o, drives grant_i)
// -----------------------------------------------------------------------------
interface bist_controller_if;
   logic req_o;
   logic grant_i;

   modport master (
      output req_o,
      input  grant_i
   );

   modport slave (
      input  req_o,
      output grant_i
   );
endinterface

// File: rtl/bist_controller.sv
// -----------------------------------------------------------------------------
// bist_controller
// Sequences one logic-BIST session: request the shared test resource, wait for
// the grant, seed LFSR/MISR, run NUM_PATTERNS shift/capture rounds, unload the
// chain into the MISR and compare the final signature against a golden value.
// Losing the grant at any point between INIT and COMPARE aborts the session.
//
// Ports
//   clk         : system clock, all state on the rising edge
//   rst         : asynchronous, active-low reset
//   start       : session request (level), only looked at in IDLE/DONE
//   arb         : request/grant handshake to the arbiter (master modport)
//   golden_sig  : expected final MISR signature, sampled in COMPARE
//   signature   : current MISR contents
//   misr_clr    : one-cycle seed/clear strobe to LFSR and MISR
//   lfsr_en     : advance LFSR and feed scan_in
//   misr_en     : MISR compacts scan_out this cycle
//   scan_en     : scan chain in shift mode
//   capture     : one-cycle functional capture strobe
//   busy        : session in progress (REQ..COMPARE)
//   done        : session finished, normally or aborted
//   pass        : signature matched golden_sig
//   abort_err   : session aborted by grant loss
//   pattern_cnt : captures completed in this session
// -----------------------------------------------------------------------------
module bist_controller #(
   parameter int SCAN_LEN     = 16,
   parameter int NUM_PATTERNS = 255,
   parameter int SIG_W        = 8,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   bist_controller_if.master  arb,
   input  logic [SIG_W-1:0]   golden_sig,
   input  logic [SIG_W-1:0]   signature,
   output logic               misr_clr,
   output logic               lfsr_en,
   output logic               misr_en,
   output logic               scan_en,
   output logic               capture,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               abort_err,
   output logic [CNT_W-1:0]   pattern_cnt
);

   localparam int               SH_W     = $clog2(SCAN_LEN);
   localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SCAN_LEN - 1);
   localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(NUM_PATTERNS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_INIT,
      S_SHIFT,
      S_CAPTURE,
      S_UNLOAD,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           state_q,       state_d;
   logic [SH_W-1:0]  shift_cnt_q,   shift_cnt_d;
   logic [CNT_W-1:0] pattern_cnt_q, pattern_cnt_d;
   logic             done_q,        done_d;
   logic             pass_q,        pass_d;
   logic             abort_q,       abort_d;

   logic             grant;
   logic             in_session;
   logic [CNT_W-1:0] pattern_inc;

   assign grant       = arb.grant_i;
   assign pattern_inc = pattern_cnt_q + CNT_W'(1);

   // The grant only matters once the resource is in use (INIT..COMPARE);
   // a grant seen in IDLE/REQ/DONE never aborts anything.
   assign in_session = (state_q == S_INIT)    || (state_q == S_SHIFT)  ||
                       (state_q == S_CAPTURE) || (state_q == S_UNLOAD) ||
                       (state_q == S_COMPARE);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         shift_cnt_q   <= '0;
         pattern_cnt_q <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_cnt_q   <= shift_cnt_d;
         pattern_cnt_q <= pattern_cnt_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         abort_q       <= abort_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      shift_cnt_d   = shift_cnt_q;
      pattern_cnt_d = pattern_cnt_q;
      done_d        = done_q;
      pass_d        = pass_q;
      abort_d       = abort_q;

      arb.req_o     = 1'b0;
      busy          = 1'b0;
      misr_clr      = 1'b0;
      lfsr_en       = 1'b0;
      misr_en       = 1'b0;
      scan_en       = 1'b0;
      capture       = 1'b0;

      // Moore decode; every enable is additionally qualified by the grant
      // so that a grant loss silences the test resource in the same cycle.
      case (state_q)
         S_REQ: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
         end
         S_INIT: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
            misr_clr  = grant;
         end
         S_SHIFT: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
            scan_en   = grant;
            lfsr_en   = grant;
            // Before the first capture the chain holds garbage; keep it
            // out of the signature.
            misr_en   = grant && (pattern_cnt_q != '0);
         end
         S_CAPTURE: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
            capture   = grant;
         end
         S_UNLOAD: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
            scan_en   = grant;
            misr_en   = grant;
         end
         S_COMPARE: begin
            arb.req_o = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase

      if (in_session && !grant) begin
         // Grant lost: abandon the session, keep pattern_cnt as a record of
         // how far it got.
         state_d = S_DONE;
         done_d  = 1'b1;
         abort_d = 1'b1;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d       = S_REQ;
                  done_d        = 1'b0;
                  pass_d        = 1'b0;
                  abort_d       = 1'b0;
                  pattern_cnt_d = '0;
               end
            end
            S_REQ: begin
               if (grant) begin
                  state_d = S_INIT;
               end
            end
            S_INIT: begin
               state_d     = S_SHIFT;
               shift_cnt_d = '0;
            end
            S_SHIFT: begin
               if (shift_cnt_q == SH_LAST) begin
                  state_d     = S_CAPTURE;
                  shift_cnt_d = '0;
               end else begin
                  shift_cnt_d = shift_cnt_q + SH_W'(1);
               end
            end
            S_CAPTURE: begin
               pattern_cnt_d = pattern_inc;
               shift_cnt_d   = '0;
               if (pattern_inc == PAT_LAST) begin
                  state_d = S_UNLOAD;
               end else begin
                  state_d = S_SHIFT;
               end
            end
            S_UNLOAD: begin
               if (shift_cnt_q == SH_LAST) begin
                  state_d     = S_COMPARE;
                  shift_cnt_d = '0;
               end else begin
                  shift_cnt_d = shift_cnt_q + SH_W'(1);
               end
            end
            S_COMPARE: begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (signature == golden_sig);
            end
            S_DONE: begin
               // Level-sensitive start: it must drop before a new session
               // can be accepted from IDLE.
               if (!start) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign abort_err   = abort_q;
   assign pattern_cnt = pattern_cnt_q;

endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;

   localparam int SCAN_LEN     = 4;
   localparam int NUM_PATTERNS = 3;
   localparam int SIG_W        = 8;
   localparam int CNT_W        = 16;
   // grant sampled -> done high: 1 + 3*(4+1) + 4 + 1
   localparam int SESSION_LEN  = 21;

   logic             clk;
   logic             rst;
   logic             start;
   logic [SIG_W-1:0] golden_sig;
   logic [SIG_W-1:0] signature;
   logic             misr_clr, lfsr_en, misr_en, scan_en, capture;
   logic             busy, done, pass, abort_err;
   logic [CNT_W-1:0] pattern_cnt;

   int errors = 0;
   int checks = 0;

   bist_controller_if arb_if ();

   bist_controller #(
      .SCAN_LEN    (SCAN_LEN),
      .NUM_PATTERNS(NUM_PATTERNS),
      .SIG_W       (SIG_W),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .arb        (arb_if.master),
      .golden_sig (golden_sig),
      .signature  (signature),
      .misr_clr   (misr_clr),
      .lfsr_en    (lfsr_en),
      .misr_en    (misr_en),
      .scan_en    (scan_en),
      .capture    (capture),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .abort_err  (abort_err),
      .pattern_cnt(pattern_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // From the INIT cycle, count cycles until done rises (bounded).
   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin
      int n_clr, n_lfsr, n_scan, n_misr, n_cap, n_done, n_req, n_misr_b1;
      int len, bad;

      rst            = 1'b0;
      start          = 1'b0;
      arb_if.grant_i = 1'b0;
      golden_sig     = 8'hA5;
      signature      = 8'hA5;

      // ---------------- reset state
      #3;
      chk("rst_outputs", {arb_if.req_o, busy, misr_clr, lfsr_en, misr_en, scan_en,
                          capture, done, pass, abort_err}, 10'd0);
      chk("rst_pcnt", pattern_cnt, 0);
      @(negedge clk);
      rst = 1'b1;

      // ---------------- 1. nominal session
      start = 1'b1;
      cyc(1);
      chk("t1_req", {arb_if.req_o, busy}, 2'b11);
      cyc(1);
      chk("t1_req_wait", {arb_if.req_o, misr_clr, scan_en}, 3'b100);
      arb_if.grant_i = 1'b1;
      cyc(1);
      n_clr = 0; n_lfsr = 0; n_scan = 0; n_misr = 0; n_cap = 0;
      n_done = 0; n_req = 0; n_misr_b1 = 0;
      for (int j = 0; j <= SESSION_LEN; j++) begin
         n_clr  += int'(misr_clr);
         n_lfsr += int'(lfsr_en);
         n_scan += int'(scan_en);
         n_misr += int'(misr_en);
         n_cap  += int'(capture);
         n_done += int'(done);
         n_req  += int'(arb_if.req_o);
         if (j >= 1 && j <= 4) n_misr_b1 += int'(misr_en);
         if (j == 0)  chk("t1_j0_init", {misr_clr, scan_en, lfsr_en}, 3'b100);
         if (j == 1)  chk("t1_j1_shift", {scan_en, lfsr_en, misr_en}, 3'b110);
         if (j == 5)  chk("t1_j5_cap", {capture, scan_en, 16'(pattern_cnt)}, {2'b10, 16'd0});
         if (j == 6)  chk("t1_j6_shift2", {misr_en, 16'(pattern_cnt)}, {1'b1, 16'd1});
         if (j == 11) chk("t1_j11_pcnt", pattern_cnt, 2);
         if (j == 16) chk("t1_j16_unload", {scan_en, misr_en, lfsr_en, 16'(pattern_cnt)},
                          {3'b110, 16'd3});
         if (j == 20) chk("t1_j20_compare", {arb_if.req_o, busy, scan_en, misr_en, lfsr_en,
                          capture, done}, 7'b1100000);
         if (j < SESSION_LEN) cyc(1);
      end
      chk("t1_cnt_clr", n_clr, 1);
      chk("t1_cnt_lfsr", n_lfsr, 12);
      chk("t1_cnt_scan", n_scan, 16);
      chk("t1_cnt_misr", n_misr, 12);
      chk("t1_misr_burst1", n_misr_b1, 0);
      chk("t1_cnt_cap", n_cap, 3);
      chk("t1_cnt_done", n_done, 1);
      chk("t1_cnt_req", n_req, 20 + 1);
      // ---------------- 2a. signature match
      chk("t2_done_match", {done, pass, abort_err, busy, arb_if.req_o}, 5'b11000);

      // ---------------- 5a. start held through DONE does not restart
      cyc(3);
      chk("t5_hold_start", {arb_if.req_o, busy, done, pass}, 4'b0011);

      // ---------------- 5b. drop and reassert start
      start = 1'b0;
      cyc(1);
      chk("t5_idle_held", {arb_if.req_o, done, pass, abort_err}, 4'b0110);
      golden_sig = 8'h5A;
      start = 1'b1;
      cyc(1);
      chk("t5_restart_clear", {arb_if.req_o, busy, done, pass}, 4'b1100);
      cyc(1);
      // ---------------- 5c. start pulsed during SHIFT, 2b. mismatch
      len = 0;
      while (!done && len < 100) begin
         if (len == 3) start = 1'b0;
         if (len == 4) start = 1'b1;
         cyc(1);
         len++;
      end
      chk("t5_pulse_len", len, SESSION_LEN);
      chk("t2_mismatch", {done, pass, abort_err, 16'(pattern_cnt)}, {3'b100, 16'd3});

      // ---------------- 3. grant loss in second SHIFT
      golden_sig = 8'hA5;
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      cyc(1);   // INIT
      cyc(7);   // second SHIFT burst, j=7
      chk("t3_pre_drop", {scan_en, lfsr_en, misr_en, busy}, 4'b1111);
      arb_if.grant_i = 1'b0;
      #1;
      chk("t3_comb_drop", {scan_en, lfsr_en, misr_en, capture, misr_clr, busy}, 6'b000001);
      cyc(1);
      chk("t3_abort", {done, abort_err, pass, arb_if.req_o, busy}, 5'b11000);
      chk("t3_pcnt", pattern_cnt, 1);

      // ---------------- 6. long wait for grant
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      chk("t6_req_clear", {done, abort_err, 16'(pattern_cnt)}, 18'd0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (!(arb_if.req_o && busy) || misr_clr || lfsr_en || misr_en || scan_en || capture)
            bad++;
         cyc(1);
      end
      chk("t6_wait_bad", bad, 0);
      arb_if.grant_i = 1'b1;
      cyc(1);
      wait_done(100, len);
      chk("t6_len", len, SESSION_LEN);
      chk("t6_pass", {done, pass, abort_err}, 3'b110);

      // ---------------- 4. async reset mid-UNLOAD
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      cyc(1);   // INIT
      cyc(17);  // UNLOAD
      chk("t4_unload", {scan_en, misr_en, lfsr_en}, 3'b110);
      #2;
      rst = 1'b0;
      #1;
      chk("t4_async_rst", {arb_if.req_o, busy, misr_clr, lfsr_en, misr_en, scan_en,
                           capture, done, pass, abort_err}, 10'd0);
      chk("t4_rst_pcnt", pattern_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1);
      chk("t4_fresh_req", {arb_if.req_o, busy, done, 16'(pattern_cnt)}, {3'b110, 16'd0});
      cyc(1);
      wait_done(100, len);
      chk("t4_len", len, SESSION_LEN);
      chk("t4_pass", {done, pass, abort_err}, 3'b110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Sequences one logic-BIST session around the LFSR pattern source, the scan chain and the 8-bit MISR compactor. It requests the shared test resource from the functional arbiter and waits for a grant. It then runs NUM_PATTERNS shift/capture rounds and unloads the chain into the MISR. Finally it compares the MISR signature with a golden value and reports pass/fail.

Parameters:
SCAN_LEN, 16, scan chain length in flops (>=2); sets cycles per shift phase.
NUM_PATTERNS, 255, capture rounds per session (>=1).
SIG_W, 8, MISR signature width.
CNT_W, 16, width of pattern counter (must hold NUM_PATTERNS).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  session request; level, sampled in IDLE/DONE only.
grant_i  input  1  arbiter grant for the BIST resource.
golden_sig  input  SIG_W  expected final signature, sampled in COMPARE.
signature  input  SIG_W  current MISR contents.
req_o  output  1  request to arbiter.
misr_clr  output  1  one-cycle seed/clear strobe to LFSR and MISR.
lfsr_en  output  1  advance LFSR and feed scan_in.
misr_en  output  1  MISR compacts scan_out this cycle.
scan_en  output  1  scan chain in shift mode.
capture  output  1  one-cycle functional capture strobe.
busy  output  1  session in progress (REQ..COMPARE).
done  output  1  session finished (normally or aborted).
pass  output  1  signature matched golden_sig.
abort_err  output  1  session aborted by grant loss.
pattern_cnt  output  CNT_W  captures completed this session.

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE; all outputs 0; counters 0. Outputs go to 0 immediately; no glitch past deassertion.
- States: IDLE, REQ, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE. Moore decode of state, except that enables are gated with grant_i.
- IDLE: start=1 -> REQ. Clears done, pass, abort_err and pattern_cnt on that transition.
- REQ: req_o=1, busy=1. Waits any number of cycles; grant_i=1 -> INIT.
- INIT (1 cycle): misr_clr=1 -> SHIFT with shift_cnt=0.
- SHIFT: scan_en=1, lfsr_en=1 for exactly SCAN_LEN cycles.
  - misr_en=0 while pattern_cnt==0 (chain contents undefined); misr_en=1 otherwise.
  - shift_cnt==SCAN_LEN-1 -> CAPTURE.
- CAPTURE (1 cycle): scan_en=0, capture=1, lfsr_en=0, misr_en=0; pattern_cnt increments.
  - New pattern_cnt==NUM_PATTERNS -> UNLOAD; else -> SHIFT with shift_cnt=0.
- UNLOAD: scan_en=1, misr_en=1, lfsr_en=0 for SCAN_LEN cycles -> COMPARE.
- COMPARE (1 cycle): all enables 0. Registers pass=(signature==golden_sig) -> DONE.
- DONE: done=1, req_o=0, busy=0; pass held.
  - start=0 -> IDLE, with done/pass/abort_err still held until the next accepted start.
  - start=1 in DONE does not restart; start must drop first.
- Session length, grant to done high: 1 + NUM_PATTERNS*(SCAN_LEN+1) + SCAN_LEN + 1 cycles.
- req_o is 1 from REQ through COMPARE inclusive.
- Grant loss: grant_i=0 in INIT..COMPARE.
  - misr_clr, lfsr_en, misr_en, scan_en and capture drop combinationally in the same cycle.
  - Next edge -> DONE with abort_err=1, pass=0, done=1; pattern_cnt frozen at its current value.
- start toggling while busy is ignored.
- grant_i asserted in IDLE/DONE is ignored.
- pattern_cnt never wraps; CNT_W must satisfy 2^CNT_W > NUM_PATTERNS.

Test Plan:
1. Nominal, SCAN_LEN=4, NUM_PATTERNS=3: start=1, grant_i=1 two cycles after req_o.
   - Required: misr_clr once; shift bursts of 4 cycles with lfsr_en; capture pulses at pattern_cnt 1,2,3.
   - misr_en low in the first burst only; 4-cycle unload; done high exactly 21 cycles after grant sampled.
2. Signature match: signature model forced to 8'hA5 and golden_sig=8'hA5 -> pass=1, done=1, abort_err=0.
   - Rerun with golden_sig=8'h5A -> pass=0.
3. Grant loss: drop grant_i during the second SHIFT.
   - Required: enables low the same cycle; next cycle done=1, abort_err=1, pass=0, pattern_cnt=1, req_o=0.
4. Async reset mid-UNLOAD: rst=0 between clock edges -> all outputs 0 immediately.
   - After release with start=1: a fresh session starts from REQ.
5. Restart rules:
   - Hold start=1 through DONE -> no new req_o.
   - Drop start, reassert -> done/pass clear, new session.
   - Pulse start during SHIFT -> no effect on sequence.
6. Long wait for grant: grant_i withheld 50 cycles -> req_o=1, busy=1, all enables 0 throughout; session proceeds normally afterwards.
